divisor_pwm_multicanal: RTL and testbench
=========================================

# divisor_pwm_multicanal

Parametrised multi-channel frequency divider / PWM generator, successor to the single-channel divider driven by an 11-bit count. Each channel produces either a 50 % divided clock (divider mode) or a PWM waveform with programmable period and duty, with glitch-free shadow-register updates applied only at period boundaries. Sits between the control FSM that computes counts and the output pins feeding the power stage.

## Interface
- CHANNELS, 4, number of independent channels (1..16)
- CNT_W, 11, counter/period/duty width in bits (4..16)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  CHANNELS  per-channel run enable
- mode  in  CHANNELS  per-channel: 0 = PWM, 1 = divider (toggle)
- load  in  CHANNELS  per-channel strobe: capture period/duty into shadow
- period  in  CHANNELS*CNT_W  flattened; channel i at [i*CNT_W +: CNT_W]
- duty  in  CHANNELS*CNT_W  flattened, same packing; ignored in divider mode
- pending  out  CHANNELS  shadow holds values not yet active
- pwm_out  out  CHANNELS  registered channel outputs
- tc  out  CHANNELS  terminal-count pulse (only with DIVISOR_TC_PULSE_EN)

## Operation
- Per channel: counter cnt (CNT_W), active regs per_a/duty_a, shadow regs per_s/duty_s, pending flag, output reg.
- load=1: per_s/duty_s <= inputs, pending <= 1.
- Wrap event: enable=1 and cnt == per_a. On wrap cnt <= 0; else cnt <= cnt+1.
- On wrap: if load same cycle, active <= inputs directly (bypass), pending <= 0; else if pending, active <= shadow, pending <= 0.
- enable=0: cnt <= 0, pwm_out <= 0; shadow transfers to active on the next cycle (pending clears); load behaves as above.
- per_a == 0: channel idle, cnt held 0, pwm_out held 0, no wrap events, pending transfers immediately as if disabled.
- PWM mode: pwm_out <= (cnt_next < duty_a); period = per_a+1 cycles; duty_a=0 → always low; duty_a > per_a → always high.
- Divider mode: pwm_out toggles on each wrap; output period = 2*(per_a+1) cycles.
- mode change takes effect only at a wrap (mode sampled into active with shadow); pwm_out restarts low in divider mode.
- Channels fully independent; no phase alignment between channels.

## Timing
- Reset: all cnt=0, per_a/duty_a/per_s/duty_s=0, pending=0, pwm_out=0, tc=0.
- pwm_out registered: one cycle from counter value to pin.
- load to pending high: 1 cycle.
- New values visible on pwm_out: cycle after the first wrap following load (worst case per_a+2 cycles).
- enable rising: cnt starts at 0 that cycle; first PWM high (if duty_a>0) appears next cycle.
- reset mid-period: all state cleared next edge, pending values lost.
- tc: 1-cycle pulse, registered, coincident with pwm_out update of the wrap cycle.

## Configuration
- DIVISOR_TC_PULSE_EN defined: tc port present and driven per wrap event.
- Not defined: tc port and its registers omitted; all other behaviour identical.

## Structure
- Package divisor_pwm_pkg: mode encodings (MODO_PWM=0, MODO_DIV=1), default CNT_W, CHANNELS limits.
- Sub-module divisor_pwm_canal: one channel (counter, shadow, pending, output); top is a generate loop plus bus slicing.

## Test plan
- Reset then CHANNELS=4, ch0 PWM period=9 duty=3 enable → pwm_out[0] 3 high / 7 low, repeating every 10 cycles (100 ns at 10 ns clock).
- ch1 divider mode period=1666 → pwm_out[1] toggles every 1667 cycles; tc pulses every 1667 cycles when DIVISOR_TC_PULSE_EN defined.
- ch0 running period=9 duty=3, load period=4 duty=2 mid-period → pending=1 until wrap, old waveform completes, then 2 high / 3 low; no runt pulse.
- Load asserted exactly on wrap cycle → new values active immediately, pending stays 0.
- duty=0 → constant low; duty=12 with period=9 → constant high; period=0 → low, counter held.
- Assert reset mid-period with pending=1 → next cycle all outputs 0, pending 0, counters 0.

Source files
------------

// File: rtl/divisor_pwm_pkg.sv
// Shared encodings and limits for the multi-channel divider / PWM block.
package divisor_pwm_pkg;

    localparam logic MODO_PWM = 1'b0;
    localparam logic MODO_DIV = 1'b1;

    localparam int CNT_W_DEF = 11;
    localparam int CNT_W_MIN = 4;
    localparam int CNT_W_MAX = 16;
    localparam int CH_MIN    = 1;
    localparam int CH_MAX    = 16;

endpackage

// File: rtl/divisor_pwm_canal.sv
// One divider/PWM channel: counter, shadow regs, pending flag, output.
// DIVISOR_TC_PULSE_EN adds a registered terminal-count pulse.
module divisor_pwm_canal
    import divisor_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             pending,
    output logic             pwm_out
`ifdef DIVISOR_TC_PULSE_EN
    ,
    output logic             tc
`endif
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_a_q, per_a_d, duty_a_q, duty_a_d;
    logic [CNT_W-1:0] per_s_q, per_s_d, duty_s_q, duty_s_d;
    logic             mode_a_q, mode_a_d, mode_s_q, mode_s_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             idle, wrap;

    assign idle = !enable || (per_a_q == '0);
    assign wrap = !idle && (cnt_q == per_a_q);

    always_comb begin
        per_s_d  = per_s_q;
        duty_s_d = duty_s_q;
        mode_s_d = mode_s_q;
        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        mode_a_d = mode_a_q;
        pend_d   = pend_q;
        if (load) begin
            per_s_d  = period;
            duty_s_d = duty;
            mode_s_d = mode;
            pend_d   = 1'b1;
        end
        // A load landing on the wrap itself bypasses the shadow.
        if (wrap && load) begin
            per_a_d  = period;
            duty_a_d = duty;
            mode_a_d = mode;
            pend_d   = 1'b0;
        end else if ((wrap || idle) && pend_q) begin
            per_a_d  = per_s_q;
            duty_a_d = duty_s_q;
            mode_a_d = mode_s_q;
            pend_d   = load;
        end

        cnt_d = (idle || wrap) ? '0 : cnt_q + 1'b1;

        out_d = out_q;
        if (idle) begin
            out_d = 1'b0;
        end else if (mode_a_d == MODO_DIV) begin
            if (wrap) out_d = (mode_a_q == MODO_DIV) ? !out_q : 1'b0;
        end else begin
            out_d = (cnt_d < duty_a_d);
        end
        if (per_a_d == '0) out_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            per_a_q  <= '0;
            duty_a_q <= '0;
            mode_a_q <= MODO_PWM;
            per_s_q  <= '0;
            duty_s_q <= '0;
            mode_s_q <= MODO_PWM;
            pend_q   <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            per_a_q  <= per_a_d;
            duty_a_q <= duty_a_d;
            mode_a_q <= mode_a_d;
            per_s_q  <= per_s_d;
            duty_s_q <= duty_s_d;
            mode_s_q <= mode_s_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
        end
    end

    assign pending = pend_q;
    assign pwm_out = out_q;

`ifdef DIVISOR_TC_PULSE_EN
    logic tc_q, tc_d;

    assign tc_d = wrap;

    always_ff @(posedge clk) begin
        if (reset) tc_q <= 1'b0;
        else       tc_q <= tc_d;
    end

    assign tc = tc_q;
`endif

endmodule

// File: rtl/divisor_pwm_multicanal.sv
// Multi-channel divider / PWM generator: one channel per bus slice.
// DIVISOR_TC_PULSE_EN exposes the per-channel tc pulse port.
module divisor_pwm_multicanal
    import divisor_pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*CNT_W-1:0] period,
    input  logic [CHANNELS*CNT_W-1:0] duty,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS-1:0]       pwm_out
`ifdef DIVISOR_TC_PULSE_EN
    ,
    output logic [CHANNELS-1:0]       tc
`endif
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_canal
        divisor_pwm_canal #(
            .CNT_W (CNT_W)
        ) u_canal (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable[i]),
            .mode    (mode[i]),
            .load    (load[i]),
            .period  (period[i*CNT_W +: CNT_W]),
            .duty    (duty[i*CNT_W +: CNT_W]),
            .pending (pending[i]),
            .pwm_out (pwm_out[i])
`ifdef DIVISOR_TC_PULSE_EN
            ,
            .tc      (tc[i])
`endif
        );
    end

endmodule

// File: tb/tb_divisor_pwm_multicanal.sv
// Directed scoreboard bench for divisor_pwm_multicanal (4 ch, 11-bit).
module tb_divisor_pwm_multicanal;

    localparam int CH = 4;
    localparam int W  = 11;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   enable, mode, load;
    logic [CH*W-1:0] period, duty;
    logic [CH-1:0]   pending, pwm_out;
`ifdef DIVISOR_TC_PULSE_EN
    logic [CH-1:0]   tc;
`endif

    typedef struct {
        logic [CH-1:0] o;
        logic [CH-1:0] p;
        logic [CH-1:0] t;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    divisor_pwm_multicanal #(
        .CHANNELS (CH),
        .CNT_W    (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .load    (load),
        .period  (period),
        .duty    (duty),
        .pending (pending),
        .pwm_out (pwm_out)
`ifdef DIVISOR_TC_PULSE_EN
        ,
        .tc      (tc)
`endif
    );

    task automatic set_ch(input int c, input int per, input int dut);
        period[c*W +: W] = per[W-1:0];
        duty[c*W +: W]   = dut[W-1:0];
    endtask

    task automatic push(input logic [CH-1:0] o, input logic [CH-1:0] p,
                        input logic [CH-1:0] t);
        exp_t e;
        e.o = o;
        e.p = p;
        e.t = t;
        q.push_back(e);
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (q.size() != 0) else begin
            failures++;
            $error("FAIL %s scoreboard empty got=%0d required=1", tag, q.size());
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            assert (pwm_out === e.o) else begin
                failures++;
                $error("FAIL %s pwm_out got=%b required=%b", tag, pwm_out, e.o);
            end
            checks++;
            assert (pending === e.p) else begin
                failures++;
                $error("FAIL %s pending got=%b required=%b", tag, pending, e.p);
            end
`ifdef DIVISOR_TC_PULSE_EN
            checks++;
            assert (tc === e.t) else begin
                failures++;
                $error("FAIL %s tc got=%b required=%b", tag, tc, e.t);
            end
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = '0;
        mode   = '0;
        load   = '0;
        period = '0;
        duty   = '0;
        @(posedge clk);
        push(4'b0, 4'b0, 4'b0);
        tick_check("reset");
        reset = 1'b0;

        // ch0 PWM period 9 duty 3, configured while disabled
        set_ch(0, 9, 3);
        load = 4'b0001;
        push(4'b0, 4'b0001, 4'b0);
        tick_check("load_pend");
        load = 4'b0;
        push(4'b0, 4'b0, 4'b0);
        tick_check("idle_xfer");
        enable[0] = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            push({3'b0, logic'((k % 10) < 3)}, 4'b0, {3'b0, logic'((k % 10) == 0)});
            tick_check("pwm_9_3");
        end

        // mid-period load: old waveform completes, then 2 high / 3 low
        set_ch(0, 4, 2);
        load = 4'b0001;
        push(4'b0, 4'b0001, 4'b0);
        tick_check("mid_load");
        load = 4'b0;
        set_ch(0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            push(4'b0, 4'b0001, 4'b0);
            tick_check("mid_hold");
        end
        for (int j = 0; j < 15; j++) begin
            push({3'b0, logic'((j % 5) < 2)}, 4'b0, {3'b0, logic'((j % 5) == 0)});
            tick_check("pwm_4_2");
        end

        // load exactly on wrap: bypass, pending stays low
        set_ch(0, 7, 5);
        load = 4'b0001;
        push(4'b0001, 4'b0, 4'b0001);
        tick_check("wrap_load");
        load = 4'b0;
        for (int j = 1; j <= 15; j++) begin
            push({3'b0, logic'((j % 8) < 5)}, 4'b0, {3'b0, logic'((j % 8) == 0)});
            tick_check("pwm_7_5");
        end

        // duty 0 loaded on wrap: constant low
        set_ch(0, 7, 0);
        load = 4'b0001;
        for (int j = 0; j < 10; j++) begin
            push(4'b0, 4'b0, {3'b0, logic'((j % 8) == 0)});
            tick_check("duty_zero");
            load = 4'b0;
        end

        // duty 12 > period 9: constant high
        enable[0] = 1'b0;
        set_ch(0, 9, 12);
        load = 4'b0001;
        push(4'b0, 4'b0001, 4'b0);
        tick_check("dis_load");
        load = 4'b0;
        push(4'b0, 4'b0, 4'b0);
        tick_check("dis_xfer");
        enable[0] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            push(4'b0001, 4'b0, {3'b0, logic'((k % 10) == 0)});
            tick_check("duty_high");
        end

        // period 0: idle, output low
        enable[0] = 1'b0;
        set_ch(0, 0, 3);
        load = 4'b0001;
        push(4'b0, 4'b0001, 4'b0);
        tick_check("per0_load");
        load = 4'b0;
        push(4'b0, 4'b0, 4'b0);
        tick_check("per0_xfer");
        enable[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push(4'b0, 4'b0, 4'b0);
            tick_check("per0_idle");
        end

        // ch1 divider period 1666: toggle every 1667 cycles
        set_ch(1, 1666, 0);
        mode[1] = 1'b1;
        load = 4'b0010;
        push(4'b0, 4'b0010, 4'b0);
        tick_check("div_load");
        load = 4'b0;
        push(4'b0, 4'b0, 4'b0);
        tick_check("div_xfer");
        enable[1] = 1'b1;
        for (int k = 1; k <= 3400; k++) begin
            push({2'b0, logic'(((k / 1667) % 2) == 1), 1'b0}, 4'b0,
                 {2'b0, logic'((k % 1667) == 0), 1'b0});
            tick_check("div_1666");
        end

        // reset mid-period with a pending load
        enable = '0;
        mode   = '0;
        set_ch(0, 9, 3);
        load = 4'b0001;
        push(4'b0, 4'b0001, 4'b0);
        tick_check("rst_prep_load");
        load = 4'b0;
        push(4'b0, 4'b0, 4'b0);
        tick_check("rst_prep_xfer");
        enable[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push({3'b0, logic'(k < 3)}, 4'b0, 4'b0);
            tick_check("rst_prep_run");
        end
        set_ch(0, 4, 2);
        load = 4'b0001;
        push(4'b0, 4'b0001, 4'b0);
        tick_check("rst_pend");
        load = 4'b0;
        reset = 1'b1;
        push(4'b0, 4'b0, 4'b0);
        tick_check("reset_mid");
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            push(4'b0, 4'b0, 4'b0);
            tick_check("post_reset");
        end

        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL leftover scoreboard got=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
